// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode constants for the alu_pipe_param datapath.
// Codes above FN_LAST are illegal and flag an error in execute.
package alu_pipe_pkg;

    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_SUB   = 4'd1;
    localparam logic [3:0] FN_MUL   = 4'd2;
    localparam logic [3:0] FN_PASSA = 4'd3;
    localparam logic [3:0] FN_PASSB = 4'd4;
    localparam logic [3:0] FN_AND   = 4'd5;
    localparam logic [3:0] FN_OR    = 4'd6;
    localparam logic [3:0] FN_XOR   = 4'd7;
    localparam logic [3:0] FN_NEGA  = 4'd8;
    localparam logic [3:0] FN_NEGB  = 4'd9;
    localparam logic [3:0] FN_SHR   = 4'd10;
    localparam logic [3:0] FN_SHL   = 4'd11;
    localparam logic [3:0] FN_LAST  = FN_SHL;

endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: purely combinational execute unit of the alu_pipe_param
// pipeline. All arithmetic wraps modulo 2^DATA_W; illegal opcodes give
// z = 0 with err set so downstream writes can be suppressed.
module alu_pipe_exec
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] z,
    output logic              err
);

    // Opcode decode; anything past FN_LAST falls to the zero/error default.
    always_comb begin
        z   = '0;
        err = (func > FN_LAST);
        case (func)
            FN_ADD:   z = a + b;
            FN_SUB:   z = a - b;
            FN_MUL:   z = a * b;
            FN_PASSA: z = a;
            FN_PASSB: z = b;
            FN_AND:   z = a & b;
            FN_OR:    z = a | b;
            FN_XOR:   z = a ^ b;
            FN_NEGA:  z = -a;
            FN_NEGB:  z = -b;
            FN_SHR:   z = a >> 1;
            FN_SHL:   z = a << 1;
            default:  z = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: four-stage register-file ALU pipeline
// (operand read, execute, register writeback, data-memory store).
// Optional macro ALU_FWD_EN: when defined, a distance-1 RAW dependency is
// resolved by forwarding the S2 result into execute; when undefined the
// pipeline stalls one cycle instead. Results are identical either way.
module alu_pipe_param
    import alu_pipe_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  NREG      = 16,
    parameter int  MEM_DEPTH = 256,
    localparam int REG_AW    = $clog2(NREG),
    localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic [MEM_AW-1:0] addr,
    input  logic              reg_we,
    input  logic              mem_we,
    output logic              out_valid,
    output logic [DATA_W-1:0] zout,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_err,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata
);

    logic [DATA_W-1:0] regbank [NREG];
    logic [DATA_W-1:0] mem     [MEM_DEPTH];

    // S1: operand latch
    logic              s1_v;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [REG_AW-1:0] s1_rd;
    logic [3:0]        s1_func;
    logic [MEM_AW-1:0] s1_addr;
    logic              s1_reg_we;
    logic              s1_mem_we;

    // S2: execute result
    logic              s2_v;
    logic [DATA_W-1:0] s2_z;
    logic              s2_err;
    logic [REG_AW-1:0] s2_rd;
    logic [MEM_AW-1:0] s2_addr;
    logic              s2_reg_we;
    logic              s2_mem_we;

    // S3: writeback stage (zout/out_rd/out_err/out_valid are its outputs)
    logic [MEM_AW-1:0] s3_addr;
    logic              s3_mem_we;

    logic              accept;
    logic              wb_en;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] ex_z;
    logic              ex_err;

    assign accept = in_valid && in_ready;
    assign wb_en  = s2_v && s2_reg_we && !s2_err;

`ifdef ALU_FWD_EN
    logic [REG_AW-1:0] s1_rs1;
    logic [REG_AW-1:0] s1_rs2;
    logic              fwd_ok;

    // Forwarding never needs to stall, so the input is only closed in reset.
    assign in_ready = !rst;

    // Only forward a value that will actually be written back; an errored
    // S2 result leaves the register untouched, as in the stalling build.
    assign fwd_ok = s2_v && s2_reg_we && !s2_err;
    assign op_a   = (fwd_ok && (s1_rs1 == s2_rd)) ? s2_z : s1_a;
    assign op_b   = (fwd_ok && (s1_rs2 == s2_rd)) ? s2_z : s1_b;

    // Keep the S1 source indices for the forwarding compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rs1 <= '0;
            s1_rs2 <= '0;
        end else if (accept) begin
            s1_rs1 <= rs1;
            s1_rs2 <= rs2;
        end
    end
`else
    logic hazard;

    // A distance-1 dependency on a register-writing S1 instruction stalls
    // one cycle; the write-through read then picks up the result.
    assign hazard   = s1_v && s1_reg_we && ((rs1 == s1_rd) || (rs2 == s1_rd));
    assign in_ready = !hazard;
    assign op_a     = s1_a;
    assign op_b     = s1_b;
`endif

    // Register read with write-through of the writeback happening this edge.
    always_comb begin
        rdata_a = regbank[rs1];
        rdata_b = regbank[rs2];
        if (wb_en && (s2_rd == rs1)) rdata_a = s2_z;
        if (wb_en && (s2_rd == rs2)) rdata_b = s2_z;
    end

    alu_pipe_exec #(
        .DATA_W (DATA_W)
    ) u_exec (
        .func (s1_func),
        .a    (op_a),
        .b    (op_b),
        .z    (ex_z),
        .err  (ex_err)
    );

    // S1: latch operands and control on accept; a missed accept is a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_rd     <= '0;
            s1_func   <= '0;
            s1_addr   <= '0;
            s1_reg_we <= 1'b0;
            s1_mem_we <= 1'b0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_a      <= rdata_a;
                s1_b      <= rdata_b;
                s1_rd     <= rd;
                s1_func   <= func;
                s1_addr   <= addr;
                s1_reg_we <= reg_we;
                s1_mem_we <= mem_we;
            end
        end
    end

    // S2: register the execute result alongside its destination/enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v      <= 1'b0;
            s2_z      <= '0;
            s2_err    <= 1'b0;
            s2_rd     <= '0;
            s2_addr   <= '0;
            s2_reg_we <= 1'b0;
            s2_mem_we <= 1'b0;
        end else begin
            s2_v      <= s1_v;
            s2_z      <= ex_z;
            s2_err    <= ex_err;
            s2_rd     <= s1_rd;
            s2_addr   <= s1_addr;
            s2_reg_we <= s1_reg_we;
            s2_mem_we <= s1_mem_we;
        end
    end

    // S3: present the result and carry the store address to the memory stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            zout      <= '0;
            out_rd    <= '0;
            out_err   <= 1'b0;
            s3_addr   <= '0;
            s3_mem_we <= 1'b0;
        end else begin
            out_valid <= s2_v;
            zout      <= s2_z;
            out_rd    <= s2_rd;
            out_err   <= s2_err;
            s3_addr   <= s2_addr;
            s3_mem_we <= s2_mem_we;
        end
    end

    // Register file: cleared by reset, written from S2 on the S3 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regbank[i] <= '0;
        end else if (wb_en) begin
            regbank[s2_rd] <= s2_z;
        end
    end

    // S4 store: contents survive reset, but nothing is written on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && out_valid && s3_mem_we && !out_err) begin
            mem[s3_addr] <= zout;
        end
    end

    // Registered read-back port; a same-edge store is seen one cycle later.
    always_ff @(posedge clk) begin
        if (rst) mem_rdata <= '0;
        else     mem_rdata <= mem[mem_raddr];
    end

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: scoreboard bench for alu_pipe_param (DATA_W=16,
// NREG=16, MEM_DEPTH=256). Builds with or without ALU_FWD_EN; only the
// expected stall count depends on the macro.
module tb_alu_pipe_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        reg_we, mem_we;
    logic        out_valid;
    logic [15:0] zout;
    logic [3:0]  out_rd;
    logic        out_err;
    logic [7:0]  mem_raddr;
    logic [15:0] mem_rdata;

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  rd;
        logic        err;
    } res_t;

    res_t        exp_q[$];
    res_t        obs_q[$];
    int          errors = 0;
    int          checks = 0;
    int          stalls = 0;
    logic [15:0] model_reg [16];
    logic [15:0] model_mem [256];

    alu_pipe_param #(
        .DATA_W    (16),
        .NREG      (16),
        .MEM_DEPTH (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .reg_we    (reg_we),
        .mem_we    (mem_we),
        .out_valid (out_valid),
        .zout      (zout),
        .out_rd    (out_rd),
        .out_err   (out_err),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Record every result the DUT presents, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) obs_q.push_back({zout, out_rd, out_err});
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] ref_alu(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
        case (fn)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a;
            4'd4:    return b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return 16'h0000 - a;
            4'd9:    return 16'h0000 - b;
            4'd10:   return {1'b0, a[15:1]};
            4'd11:   return {a[14:0], 1'b0};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic preload(input int idx, input logic [15:0] val);
        dut.regbank[idx] <= val;
        model_reg[idx] = val;
    endtask

    // Drive one instruction starting just after a negedge, push its expected
    // result, and return at the negedge after it was accepted.
    task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rdst,
                         input logic [3:0] fn, input logic [7:0] ad, input logic rwe, input logic mwe);
        res_t e;
        int   waited;
        e.rd  = rdst;
        e.err = (fn > 4'd11);
        e.z   = ref_alu(fn, model_reg[ra], model_reg[rb]);
        if (rwe && !e.err) model_reg[rdst] = e.z;
        if (mwe && !e.err) model_mem[ad] = e.z;
        exp_q.push_back(e);
        in_valid = 1'b1; rs1 = ra; rs2 = rb; rd = rdst; func = fn;
        addr = ad; reg_we = rwe; mem_we = mwe;
        #1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 8) begin
            stalls++; waited++;
            @(negedge clk); #1;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0;
        addr = '0; reg_we = 1'b0; mem_we = 1'b0; mem_raddr = '0;
        for (int i = 0; i < 16; i++) model_reg[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 6;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        if (zout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_zout: got %h required 0000", zout); end
        if (out_rd !== 4'd0) begin errors++; $display("[TB] FAIL reset_out_rd: got %0d required 0", out_rd); end
        if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b required 0", out_err); end
        if (mem_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_rdata: got %h required 0000", mem_rdata); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        res_t e, o;
        issue(4'd1, 4'd2, 4'd3, 4'd0, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b0;
        preload(1, 16'd5);
        preload(2, 16'd3);
        @(negedge clk);
        issue(4'd1, 4'd2, 4'd3, 4'd0, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency_early: out_valid=%b required 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || zout !== 16'd8 || out_rd !== 4'd3)
            begin errors++; $display("[TB] FAIL basic_latency: valid=%b z=%h rd=%0d required 1/0008/3", out_valid, zout, out_rd); end
        issue(4'd3, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL basic_missing: no result, required z=%h rd=%0d", e.z, e.rd); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL basic_result: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL basic_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        int   want;
`ifdef ALU_FWD_EN
        want = 0;
`else
        want = 1;
`endif
        stalls = 0;
        issue(4'd3, 4'd3, 4'd4, 4'd0, 8'h00, 1'b1, 1'b0);
        issue(4'd4, 4'd1, 4'd5, 4'd0, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (stalls !== want) begin errors++; $display("[TB] FAIL b2b_stalls: got %0d stall cycles required %0d", stalls, want); end
        repeat (3) @(negedge clk);
        issue(4'd5, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (model_reg[5] !== 16'd21) begin errors++; $display("[TB] FAIL b2b_model: r5 model %0d required 21", model_reg[5]); end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL b2b_missing: no result, required z=%h rd=%0d", e.z, e.rd); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL b2b_result: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_dist2();
        res_t e, o;
        stalls = 0;
        issue(4'd3, 4'd0, 4'd4, 4'd3, 8'h00, 1'b1, 1'b0);
        issue(4'd1, 4'd2, 4'd9, 4'd7, 8'h00, 1'b1, 1'b0);
        issue(4'd4, 4'd1, 4'd10, 4'd0, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (stalls !== 0) begin errors++; $display("[TB] FAIL dist2_stalls: got %0d stall cycles required 0", stalls); end
        repeat (3) @(negedge clk);
        issue(4'd10, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        issue(4'd4, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL dist2_missing: no result, required z=%h rd=%0d", e.z, e.rd); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL dist2_result: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL dist2_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_boundary();
        res_t e, o;
        logic [15:0] lit [10];
        int          n;
        lit = '{16'h0000, 16'h0000, 16'hFFFF, 16'h4000, 16'h0002,
                16'h0002, 16'h7FFF, 16'h8001, 16'h0101, 16'h0100};
        preload(11, 16'hFFFF);
        preload(12, 16'h0001);
        preload(13, 16'h0100);
        preload(14, 16'h8001);
        @(negedge clk);
        issue(4'd11, 4'd12, 4'd15, 4'd0,  8'h00, 1'b0, 1'b0);
        issue(4'd13, 4'd13, 4'd15, 4'd2,  8'h00, 1'b0, 1'b0);
        issue(4'd12, 4'd0,  4'd15, 4'd8,  8'h00, 1'b0, 1'b0);
        issue(4'd14, 4'd0,  4'd15, 4'd10, 8'h00, 1'b0, 1'b0);
        issue(4'd14, 4'd0,  4'd15, 4'd11, 8'h00, 1'b0, 1'b0);
        issue(4'd12, 4'd11, 4'd15, 4'd1,  8'h00, 1'b0, 1'b0);
        issue(4'd0,  4'd14, 4'd15, 4'd9,  8'h00, 1'b0, 1'b0);
        issue(4'd11, 4'd14, 4'd15, 4'd5,  8'h00, 1'b0, 1'b0);
        issue(4'd13, 4'd12, 4'd15, 4'd6,  8'h00, 1'b0, 1'b0);
        issue(4'd0,  4'd13, 4'd15, 4'd4,  8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (e.z !== lit[n]) $display("[TB] note: model z=%h differs from table %h at %0d", e.z, lit[n], n);
            e.z = lit[n]; n++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL boundary_missing: no result, required z=%h", e.z); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL boundary_%0d: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", n - 1, o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL boundary_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_illegal();
        res_t e, o;
        issue(4'd1, 4'd0, 4'd0, 4'd3, 8'h10, 1'b0, 1'b1);
        issue(4'd1, 4'd2, 4'd3, 4'd13, 8'h10, 1'b1, 1'b1);
        issue(4'd1, 4'd2, 4'd9, 4'd7, 8'h00, 1'b0, 1'b0);
        issue(4'd2, 4'd2, 4'd9, 4'd7, 8'h00, 1'b0, 1'b0);
        issue(4'd3, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        mem_raddr = 8'h10;
        repeat (4) @(negedge clk);
        checks++;
        if (mem_rdata !== 16'd5) begin errors++; $display("[TB] FAIL illegal_mem: mem[10]=%h required 0005", mem_rdata); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL illegal_missing: no result, required z=%h rd=%0d", e.z, e.rd); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL illegal_result: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL illegal_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_mem_readback();
        res_t e, o;
        int   waited;
        preload(6, 16'h1234);
        preload(7, 16'hBEEF);
        @(negedge clk);
        issue(4'd6, 4'd0, 4'd0, 4'd3, 8'hFF, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        mem_raddr = 8'hFF;
        @(negedge clk);
        checks++;
        if (mem_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL mem_readback: got %h required 1234", mem_rdata); end
        issue(4'd7, 4'd0, 4'd0, 4'd3, 8'hFF, 1'b0, 1'b1);
        in_valid = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 6) begin @(negedge clk); waited++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mem_store_timeout: out_valid=%b required 1", out_valid); end
        @(negedge clk);
        checks++;
        if (mem_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL mem_rdw_old: got %h required 1234", mem_rdata); end
        @(negedge clk);
        checks++;
        if (mem_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL mem_rdw_new: got %h required beef", mem_rdata); end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL mem_missing: no result, required z=%h rd=%0d", e.z, e.rd); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL mem_result: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL mem_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_inflight();
        res_t e, o;
        logic [15:0] saved;
        saved = model_mem[8'h10];
        issue(4'd1, 4'd2, 4'd1, 4'd0, 8'h10, 1'b1, 1'b1);
        issue(4'd2, 4'd2, 4'd2, 4'd0, 8'h10, 1'b1, 1'b1);
        issue(4'd3, 4'd3, 4'd3, 4'd6, 8'h10, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_flight_valid: out_valid=%b required 0", out_valid); end
        if (zout !== 16'h0000) begin errors++; $display("[TB] FAIL rst_flight_zout: zout=%h required 0000", zout); end
        for (int i = 0; i < 16; i++) model_reg[i] = '0;
        model_mem[8'h10] = saved;
        mem_raddr = 8'h10;
        @(negedge clk);
        checks++;
        if (mem_rdata !== 16'd5) begin errors++; $display("[TB] FAIL rst_flight_mem: mem[10]=%h required 0005", mem_rdata); end
        issue(4'd1, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        issue(4'd0, 4'd2, 4'd0, 4'd4, 8'h00, 1'b0, 1'b0);
        issue(4'd7, 4'd0, 4'd0, 4'd3, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL rst_flight_missing: no result, required z=%h rd=%0d", e.z, e.rd); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("[TB] FAIL rst_flight_result: z=%h rd=%0d err=%b required z=%h rd=%0d err=%b", o.z, o.rd, o.err, e.z, e.rd, e.err); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL rst_flight_extra: %0d unexpected results, required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        $display("[TB] starting alu_pipe_param bench");
        test_reset();
        test_basic();
        test_back_to_back();
        test_dist2();
        test_boundary();
        test_illegal();
        test_mem_readback();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe_param.md
# alu_pipe_param

Parametrised four-stage register-file ALU pipeline with one clock. Stages: operand read, execute, register writeback, data-memory store. It adds a valid/ready input handshake, RAW hazard resolution (forwarding or stall), per-instruction write enables, an error flag and a memory read-back port. It sits between the instruction source and the data memory as the datapath core of the processor.

## Interface
- DATA_W, 16, operand/result width (≥4)
- NREG, 16, register count (power of 2); REG_AW = log2(NREG)
- MEM_DEPTH, 256, data memory words (power of 2); MEM_AW = log2(MEM_DEPTH)

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted this edge when in_valid && in_ready
- rs1, rs2  in  REG_AW  source registers
- rd  in  REG_AW  destination register
- func  in  4  opcode
- addr  in  MEM_AW  store address
- reg_we  in  1  write result to rd
- mem_we  in  1  store result to addr
- out_valid  out  1  result in stage 3 valid (single-cycle pulse per instruction)
- zout  out  DATA_W  stage-3 result
- out_rd  out  REG_AW  stage-3 destination
- out_err  out  1  stage-3 instruction had illegal func
- mem_raddr  in  MEM_AW  read-back address
- mem_rdata  out  DATA_W  mem[mem_raddr] registered, 1-cycle latency

## Operation
- S1 (accept edge): A <= regbank[rs1], B <= regbank[rs2]. Latches rd, func, addr, reg_we, mem_we and v1 <= accept.
- Write-through: a read of the index being written by the regbank write on the same edge returns the new data.
- S2: Z <= f(func, A', B'). A'/B' are the forwarded operands (see Configuration). Carries rd/addr/enables; v2 <= v1.
- S3: if v2 && reg_we && !err, regbank[rd] <= Z. zout/out_rd/out_err/out_valid <= S2 contents.
- S4: if v3 && mem_we && !err, mem[addr] <= zout.
- func codes:
  - 0 add
  - 1 sub
  - 2 mul (low DATA_W bits)
  - 3 pass A
  - 4 pass B
  - 5 and
  - 6 or
  - 7 xor
  - 8 −A
  - 9 −B
  - 10 logical A>>1
  - 11 A<<1
- All arithmetic is modulo 2^DATA_W, two's complement.
- func 12–15: Z = 0, err = 1. Both the regbank write and the mem write are suppressed.
- A bubble (v=0) never writes the regbank or memory.
- Downstream never back-pressures.

## Timing
- Accept at edge k. Result reaches zout/out_valid after edge k+2. Regbank is updated at edge k+2. Memory is written at edge k+3.
- Throughput is 1 instruction/clock with no hazard.
- Dependent instruction at distance 1 (accepted at k+1):
  - with ALU_FWD_EN, S2 result is forwarded into execute at k+2, with zero penalty;
  - otherwise it stalls.
- Distance 2 is covered by write-through. Distance ≥3 reads the updated regbank.
- Hazard condition (distance 1): v1 && reg_we(S1) && (rs1==rd(S1) || rs2==rd(S1)). reg_we of the new instruction is irrelevant.
- in_ready is combinational from rs1/rs2 and S1 state. in_valid may depend on in_ready only through registered logic.
- mem_rdata: read-during-write on the same address returns the old data.
- Reset (rst high at an edge):
  - in_ready=1; all v flags = 0; out_valid=0, zout=0, out_rd=0, out_err=0, mem_rdata=0;
  - regbank cleared to 0; memory contents preserved;
  - in-flight instructions are discarded, and no writes happen on the reset edge.

## Configuration
- ALU_FWD_EN defined:
  - execute operand = S2.Z when v2 && reg_we(S2) && rsX(S1)==rd(S2), else the S1 latch;
  - in_ready is held 1 except during reset.
- ALU_FWD_EN undefined:
  - no forwarding mux;
  - in_ready = !hazard; one stall cycle inserts a bubble into S1;
  - result values are identical to the forwarded build, only timing differs.

## Structure
- Package alu_pipe_pkg: func code localparams (FN_ADD…FN_SHL), FN_LAST=11.
- Sub-module alu_pipe_exec: purely combinational, parameter DATA_W. Inputs func, a, b; outputs z, err. Instantiated once in S2.
- Top holds the regbank, the memory array, the pipeline registers, the hazard/forward logic and the read-back port.

## Test plan
- Reset, then load r1=5, r2=3 (func 3 of preloaded values via reset-cleared + add chain) → zout=0 for first adds; after setup, func 0 r1,r2→r3 gives zout=8 two edges after accept, and r3=8 readable.
- Back-to-back dependent instructions:
  - setup: r3=8;
  - r4=r3+r3, then r5=r4+r1 (r1=5) in consecutive cycles;
  - FWD build: r5=21 with no stall and in_ready stays 1;
  - non-FWD build: one cycle with in_ready=0, same result.
- Distance-2 dependency through write-through → correct value. r4=r3 unaffected by an intervening unrelated op.
- DATA_W=16: 0xFFFF+1 → 0; 0x0100×0x0100 → 0; −0x0001 → 0xFFFF; 0x8001>>1 → 0x4000; 0x8001<<1 → 0x0002.
- func=13 with reg_we=mem_we=1 → zout=0, out_err=1, rd and mem[addr] unchanged.
- mem_we to addr 0xFF with Z=0x1234 → mem_rdata=0x1234 one cycle after mem_raddr=0xFF, following the store edge.
- Assert rst while 3 instructions are in flight → no regbank/mem writes, out_valid=0 next cycle, regbank reads 0.
